// File: rtl/fifo_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_buffer_ctrl
// 15-entry synchronous FIFO: control logic plus storage. Write and read
// addresses come from external ring counters (WriteReg/ReadReg); this block
// drives their advance enables (WriteEn/ReadEn), tracks occupancy and holds
// the register array.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags, cleared only by rst_n
//   undefined -> overflow/underflow tied to 0, no extra flops
// -----------------------------------------------------------------------------
module fifo_buffer_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 15,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        WriteReg,
    input  logic [3:0]        ReadReg,
    output logic              WriteEn,
    output logic              ReadEn,
    output logic [DATA_W-1:0] data_out,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    // Pointer code the counters never produce; it addresses no storage.
    localparam logic [3:0]       PTR_ILLEGAL = 4'hF;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] rd_word;

    // Requests are accepted only against the registered flags, so the
    // enables never depend on the incoming pointers.
    assign WriteEn = push & ~full;
    assign ReadEn  = pop & ~empty;

    // Next occupancy: +1 push only, -1 pop only, otherwise unchanged.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
        count_next = count;
        case ({WriteEn, ReadEn})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Occupancy counter with full/empty registered from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_C);
        end
    end

    // Storage write on an accepted push; the illegal pointer is never written.
    // NOTE: the array has no reset; empty=1 after reset makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (WriteEn && (WriteReg != PTR_ILLEGAL)) begin
            mem[WriteReg] <= data_in;
        end
    end

    // Read word selection; the illegal pointer returns zero.
    always_comb begin
        rd_word = '0;
        if (ReadReg != PTR_ILLEGAL) begin
            rd_word = mem[ReadReg];
        end
    end

    // Registered read port: data_out updates and dout_valid pulses on an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= ReadEn;
            if (ReadEn) begin
                data_out <= rd_word;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags: any push while full / pop while empty, held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
